// File: rtl/axi_lite_req_scheduler.sv
// Purpose : round-robin front end that funnels NREQ single-beat requesters onto one AXI4-Lite master.
// Latency : REQ_VALID to AW/W or AR VALID is 1 cycle; REQ_DONE pulses 1 cycle after the B/R handshake.
// Backpress: every M_AXI VALID and its payload hold until READY; REQ_VALID is held until REQ_DONE.
//
// Ports:
//   ACLK, ARESETn          clock and asynchronous active-low reset
//   REQ_VALID/WRITE        per-requester request strobe and direction (1 = write)
//   REQ_ADDR/WDATA/WSTRB   packed request payloads, requester i in slice i
//   REQ_DONE               one-hot completion pulse to the granted requester
//   REQ_RDATA/REQ_RESP     read data and BRESP/RRESP, valid while REQ_DONE is high
//   M_AXI_*                AXI4-Lite master channels AW, W, B, AR, R
module axi_lite_req_scheduler #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic [NREQ-1:0]            REQ_VALID,
  input  logic [NREQ-1:0]            REQ_WRITE,
  input  logic [NREQ*ADDR_W-1:0]     REQ_ADDR,
  input  logic [NREQ*DATA_W-1:0]     REQ_WDATA,
  input  logic [NREQ*DATA_W/8-1:0]   REQ_WSTRB,
  output logic [NREQ-1:0]            REQ_DONE,
  output logic [DATA_W-1:0]          REQ_RDATA,
  output logic [1:0]                 REQ_RESP,
  output logic [ADDR_W-1:0]          M_AXI_AWADDR,
  output logic                       M_AXI_AWVALID,
  input  logic                       M_AXI_AWREADY,
  output logic [2:0]                 M_AXI_AWPROT,
  output logic [DATA_W-1:0]          M_AXI_WDATA,
  output logic [DATA_W/8-1:0]        M_AXI_WSTRB,
  output logic                       M_AXI_WVALID,
  input  logic                       M_AXI_WREADY,
  input  logic [1:0]                 M_AXI_BRESP,
  input  logic                       M_AXI_BVALID,
  output logic                       M_AXI_BREADY,
  output logic [ADDR_W-1:0]          M_AXI_ARADDR,
  output logic                       M_AXI_ARVALID,
  input  logic                       M_AXI_ARREADY,
  output logic [2:0]                 M_AXI_ARPROT,
  input  logic [DATA_W-1:0]          M_AXI_RDATA,
  input  logic [1:0]                 M_AXI_RRESP,
  input  logic                       M_AXI_RVALID,
  output logic                       M_AXI_RREADY
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    WAIT_B = 3'd2,
    RD     = 3'd3,
    WAIT_R = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          resp_q, resp_d;
  logic [NREQ-1:0]     done_q, done_d;

  // Round-robin search: first requester at or above ptr_q, wrapping to 0.
  // cand is one bit wider than the index so ptr+k never overflows before the wrap.
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_vld;
  logic [IDX_W:0]      cand;

  always_comb begin
    arb_idx = '0;
    arb_vld = 1'b0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NREQ)) begin
        cand = cand - (IDX_W+1)'(NREQ);
      end
      if (!arb_vld && REQ_VALID[cand[IDX_W-1:0]]) begin
        arb_vld = 1'b1;
        arb_idx = cand[IDX_W-1:0];
      end
    end
  end

  // Next-state and next-output logic. All outputs are registered, so this
  // block computes the value every output register takes on the next edge.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    done_d    = '0;

    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          grant_d = arb_idx;
          if (REQ_WRITE[arb_idx]) begin
            awaddr_d  = REQ_ADDR[arb_idx*ADDR_W +: ADDR_W];
            wdata_d   = REQ_WDATA[arb_idx*DATA_W +: DATA_W];
            wstrb_d   = REQ_WSTRB[arb_idx*STRB_W +: STRB_W];
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            araddr_d  = REQ_ADDR[arb_idx*ADDR_W +: ADDR_W];
            arvalid_d = 1'b1;
            state_d   = RD;
          end
        end
      end

      WR: begin
        // AW and W retire independently; BREADY goes up once both are gone.
        if (M_AXI_AWREADY) begin
          awvalid_d = 1'b0;
        end
        if (M_AXI_WREADY) begin
          wvalid_d = 1'b0;
        end
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WAIT_B;
        end
      end

      WAIT_B: begin
        if (M_AXI_BVALID && bready_q) begin
          resp_d          = M_AXI_BRESP;
          bready_d        = 1'b0;
          done_d[grant_q] = 1'b1;
          state_d         = DONE;
        end
      end

      RD: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = WAIT_R;
        end
      end

      WAIT_R: begin
        if (M_AXI_RVALID && rready_q) begin
          rdata_d         = M_AXI_RDATA;
          resp_d          = M_AXI_RRESP;
          rready_d        = 1'b0;
          done_d[grant_q] = 1'b1;
          state_d         = DONE;
        end
      end

      DONE: begin
        // REQ_DONE is high for this single cycle; the requester just served
        // drops to lowest priority for the next arbitration.
        if (grant_q == IDX_W'(NREQ - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = grant_q + 1'b1;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      done_q    <= done_d;
    end
  end

  assign REQ_DONE      = done_q;
  assign REQ_RDATA     = rdata_q;
  assign REQ_RESP      = resp_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_req_scheduler.sv
// Purpose : directed bench for axi_lite_req_scheduler with a cycle-stepped AXI4-Lite slave.
// Latency : inputs change and outputs are sampled 1 time unit after each rising edge.
// Backpress: slave READY/VALID timing is set per transaction by explicit delay arguments.
module tb_axi_lite_req_scheduler;

  logic        ACLK;
  logic        ARESETn;
  logic [1:0]  REQ_VALID;
  logic [1:0]  REQ_WRITE;
  logic [63:0] REQ_ADDR;
  logic [63:0] REQ_WDATA;
  logic [7:0]  REQ_WSTRB;
  logic [1:0]  REQ_DONE;
  logic [31:0] REQ_RDATA;
  logic [1:0]  REQ_RESP;
  logic [31:0] M_AXI_AWADDR;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [2:0]  M_AXI_AWPROT;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;
  logic [31:0] M_AXI_ARADDR;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [2:0]  M_AXI_ARPROT;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_rdata = 32'h0;

  axi_lite_req_scheduler #(.NREQ(2), .ADDR_W(32), .DATA_W(32)) dut (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .REQ_VALID     (REQ_VALID),
    .REQ_WRITE     (REQ_WRITE),
    .REQ_ADDR      (REQ_ADDR),
    .REQ_WDATA     (REQ_WDATA),
    .REQ_WSTRB     (REQ_WSTRB),
    .REQ_DONE      (REQ_DONE),
    .REQ_RDATA     (REQ_RDATA),
    .REQ_RESP      (REQ_RESP),
    .M_AXI_AWADDR  (M_AXI_AWADDR),
    .M_AXI_AWVALID (M_AXI_AWVALID),
    .M_AXI_AWREADY (M_AXI_AWREADY),
    .M_AXI_AWPROT  (M_AXI_AWPROT),
    .M_AXI_WDATA   (M_AXI_WDATA),
    .M_AXI_WSTRB   (M_AXI_WSTRB),
    .M_AXI_WVALID  (M_AXI_WVALID),
    .M_AXI_WREADY  (M_AXI_WREADY),
    .M_AXI_BRESP   (M_AXI_BRESP),
    .M_AXI_BVALID  (M_AXI_BVALID),
    .M_AXI_BREADY  (M_AXI_BREADY),
    .M_AXI_ARADDR  (M_AXI_ARADDR),
    .M_AXI_ARVALID (M_AXI_ARVALID),
    .M_AXI_ARREADY (M_AXI_ARREADY),
    .M_AXI_ARPROT  (M_AXI_ARPROT),
    .M_AXI_RDATA   (M_AXI_RDATA),
    .M_AXI_RRESP   (M_AXI_RRESP),
    .M_AXI_RVALID  (M_AXI_RVALID),
    .M_AXI_RREADY  (M_AXI_RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
    REQ_VALID[idx]           = 1'b1;
    REQ_WRITE[idx]           = wr;
    REQ_ADDR[idx*32 +: 32]   = addr;
    REQ_WDATA[idx*32 +: 32]  = data;
    REQ_WSTRB[idx*4 +: 4]    = strb;
  endtask

  // Called in an IDLE cycle with requests already driven. Steps the slave
  // side of one transaction and returns in the IDLE cycle after DONE.
  task automatic service(input int g, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb,
                         input int a_dly, input int w_dly, input int rsp_dly,
                         input logic [1:0] rsp, input logic [31:0] rd);
    int cyc;
    int need;
    bit a_done;
    bit w_done;
    tick;
    if (wr) begin
      chk("aw_latency", 32'(M_AXI_AWVALID), 32'd1);
      chk("w_latency", 32'(M_AXI_WVALID), 32'd1);
      chk("ar_quiet", 32'(M_AXI_ARVALID), 32'd0);
      cyc = 0; a_done = 0; w_done = 0;
      while (!(a_done && w_done) && cyc < 50) begin
        M_AXI_AWREADY = !a_done && (cyc >= a_dly);
        M_AXI_WREADY  = !w_done && (cyc >= w_dly);
        chk("awvalid", 32'(M_AXI_AWVALID), 32'(!a_done));
        chk("wvalid", 32'(M_AXI_WVALID), 32'(!w_done));
        if (!a_done) chk("awaddr", M_AXI_AWADDR, addr);
        if (!w_done) chk("wdata", M_AXI_WDATA, data);
        if (!w_done) chk("wstrb", 32'(M_AXI_WSTRB), 32'(strb));
        chk("bready_early", 32'(M_AXI_BREADY), 32'd0);
        if (M_AXI_AWREADY) a_done = 1;
        if (M_AXI_WREADY)  w_done = 1;
        tick;
        cyc++;
      end
      M_AXI_AWREADY = 1'b0;
      M_AXI_WREADY  = 1'b0;
      need = ((a_dly > w_dly) ? a_dly : w_dly) + 1;
      chk("wr_cycles", 32'(cyc), 32'(need));
      chk("aw_drop", 32'(M_AXI_AWVALID), 32'd0);
      chk("w_drop", 32'(M_AXI_WVALID), 32'd0);
      chk("bready_up", 32'(M_AXI_BREADY), 32'd1);
      for (int i = 0; i < rsp_dly; i++) begin
        chk("bready_hold", 32'(M_AXI_BREADY), 32'd1);
        chk("done_early", 32'(REQ_DONE), 32'd0);
        tick;
      end
      M_AXI_BVALID = 1'b1;
      M_AXI_BRESP  = rsp;
      tick;
      M_AXI_BVALID = 1'b0;
      M_AXI_BRESP  = 2'b00;
      chk("bready_drop", 32'(M_AXI_BREADY), 32'd0);
    end else begin
      chk("ar_latency", 32'(M_AXI_ARVALID), 32'd1);
      chk("aw_quiet", 32'(M_AXI_AWVALID), 32'd0);
      cyc = 0; a_done = 0;
      while (!a_done && cyc < 50) begin
        M_AXI_ARREADY = (cyc >= a_dly);
        chk("arvalid", 32'(M_AXI_ARVALID), 32'd1);
        chk("araddr", M_AXI_ARADDR, addr);
        chk("rready_early", 32'(M_AXI_RREADY), 32'd0);
        a_done = M_AXI_ARREADY;
        tick;
        cyc++;
      end
      M_AXI_ARREADY = 1'b0;
      chk("ar_cycles", 32'(cyc), 32'(a_dly + 1));
      chk("ar_drop", 32'(M_AXI_ARVALID), 32'd0);
      chk("rready_up", 32'(M_AXI_RREADY), 32'd1);
      for (int i = 0; i < rsp_dly; i++) begin
        chk("rready_hold", 32'(M_AXI_RREADY), 32'd1);
        chk("done_early", 32'(REQ_DONE), 32'd0);
        tick;
      end
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = rd;
      M_AXI_RRESP  = rsp;
      tick;
      M_AXI_RVALID = 1'b0;
      M_AXI_RDATA  = 32'h0;
      M_AXI_RRESP  = 2'b00;
      chk("rready_drop", 32'(M_AXI_RREADY), 32'd0);
      exp_rdata = rd;
    end
    chk("req_done", 32'(REQ_DONE), 32'd1 << g);
    chk("req_resp", 32'(REQ_RESP), 32'(rsp));
    chk("req_rdata", REQ_RDATA, exp_rdata);
    tick;
    chk("done_clear", 32'(REQ_DONE), 32'd0);
  endtask

  initial begin
    ARESETn       = 1'b0;
    REQ_VALID     = '0;
    REQ_WRITE     = '0;
    REQ_ADDR      = '0;
    REQ_WDATA     = '0;
    REQ_WSTRB     = '0;
    M_AXI_AWREADY = 1'b0;
    M_AXI_WREADY  = 1'b0;
    M_AXI_BRESP   = 2'b00;
    M_AXI_BVALID  = 1'b0;
    M_AXI_ARREADY = 1'b0;
    M_AXI_RDATA   = 32'h0;
    M_AXI_RRESP   = 2'b00;
    M_AXI_RVALID  = 1'b0;

    // Reset values
    #23;
    chk("rst_awvalid", 32'(M_AXI_AWVALID), 32'd0);
    chk("rst_wvalid", 32'(M_AXI_WVALID), 32'd0);
    chk("rst_arvalid", 32'(M_AXI_ARVALID), 32'd0);
    chk("rst_bready", 32'(M_AXI_BREADY), 32'd0);
    chk("rst_rready", 32'(M_AXI_RREADY), 32'd0);
    chk("rst_done", 32'(REQ_DONE), 32'd0);
    chk("rst_rdata", REQ_RDATA, 32'd0);
    chk("rst_resp", 32'(REQ_RESP), 32'd0);
    chk("rst_awaddr", M_AXI_AWADDR, 32'd0);
    chk("rst_araddr", M_AXI_ARADDR, 32'd0);
    chk("rst_wdata", M_AXI_WDATA, 32'd0);
    chk("rst_wstrb", 32'(M_AXI_WSTRB), 32'd0);
    chk("awprot", 32'(M_AXI_AWPROT), 32'd0);
    chk("arprot", 32'(M_AXI_ARPROT), 32'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    tick;

    // Single write from requester 0, slave ready immediately
    set_req(0, 1'b1, 32'h4, 32'h12345678, 4'hF);
    service(0, 1'b1, 32'h4, 32'h12345678, 4'hF, 0, 0, 0, 2'b00, 32'h0);
    REQ_VALID = '0;
    tick;

    // Read back from requester 1
    set_req(1, 1'b0, 32'h4, 32'h0, 4'h0);
    service(1, 1'b0, 32'h4, 32'h0, 4'h0, 0, 0, 1, 2'b00, 32'h12345678);
    REQ_VALID = '0;
    tick;

    // Both held: grants alternate 0,1,0,1 (pointer is 0 after the read by 1)
    set_req(0, 1'b1, 32'h10, 32'hA5A50001, 4'h3);
    set_req(1, 1'b0, 32'h20, 32'h0, 4'h0);
    service(0, 1'b1, 32'h10, 32'hA5A50001, 4'h3, 1, 0, 0, 2'b11, 32'h0);
    service(1, 1'b0, 32'h20, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'h0BADF00D);
    service(0, 1'b1, 32'h10, 32'hA5A50001, 4'h3, 0, 1, 0, 2'b00, 32'h0);
    service(1, 1'b0, 32'h20, 32'h0, 4'h0, 2, 0, 2, 2'b01, 32'hCAFE0042);
    REQ_VALID = '0;
    tick;

    // WREADY 3 cycles ahead of AWREADY, then the reverse
    set_req(0, 1'b1, 32'h8, 32'h55AA33CC, 4'h5);
    service(0, 1'b1, 32'h8, 32'h55AA33CC, 4'h5, 3, 0, 1, 2'b00, 32'h0);
    REQ_VALID = '0;
    tick;
    set_req(0, 1'b1, 32'hC, 32'h0F0F0F0F, 4'hA);
    service(0, 1'b1, 32'hC, 32'h0F0F0F0F, 4'hA, 0, 3, 2, 2'b00, 32'h0);
    REQ_VALID = '0;
    tick;

    // ARREADY stalled 5 cycles, RRESP = SLVERR
    set_req(0, 1'b0, 32'h30, 32'h0, 4'h0);
    service(0, 1'b0, 32'h30, 32'h0, 4'h0, 5, 0, 1, 2'b10, 32'hDEADBEEF);
    REQ_VALID = '0;
    tick;

    // Reset while in WAIT_B; pointer is 1 here (last grant was 0)
    set_req(0, 1'b1, 32'h40, 32'h11112222, 4'hF);
    tick;
    chk("pre_rst_aw", 32'(M_AXI_AWVALID), 32'd1);
    M_AXI_AWREADY = 1'b1;
    M_AXI_WREADY  = 1'b1;
    tick;
    M_AXI_AWREADY = 1'b0;
    M_AXI_WREADY  = 1'b0;
    chk("pre_rst_bready", 32'(M_AXI_BREADY), 32'd1);
    #2;
    ARESETn = 1'b0;
    #1;
    chk("arst_bready", 32'(M_AXI_BREADY), 32'd0);
    chk("arst_awvalid", 32'(M_AXI_AWVALID), 32'd0);
    chk("arst_wvalid", 32'(M_AXI_WVALID), 32'd0);
    chk("arst_arvalid", 32'(M_AXI_ARVALID), 32'd0);
    chk("arst_rready", 32'(M_AXI_RREADY), 32'd0);
    chk("arst_done", 32'(REQ_DONE), 32'd0);
    chk("arst_rdata", REQ_RDATA, 32'd0);
    chk("arst_awaddr", M_AXI_AWADDR, 32'd0);
    REQ_VALID = '0;
    exp_rdata = 32'h0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    tick;

    // Fresh traffic after reset: both request, pointer must be back at 0
    set_req(0, 1'b1, 32'h44, 32'h76543210, 4'hC);
    set_req(1, 1'b0, 32'h50, 32'h0, 4'h0);
    service(0, 1'b1, 32'h44, 32'h76543210, 4'hC, 0, 0, 0, 2'b00, 32'h0);
    REQ_VALID = '0;
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_lite_req_scheduler.md
Name: axi_lite_req_scheduler

Overview:
Multi-requester front end for one AXI4-Lite master port. Accepts simple single-beat read/write requests from NREQ local requesters and arbitrates them round-robin. Sequences each granted request through the AXI4-Lite channels, one outstanding transaction at a time, and returns read data and response to the granted requester. Sits between on-chip control logic, such as test sequencers and config engines, and the shared AXI4-Lite slave/register bank.

Parameters:
NREQ, 2, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETn  in  1  asynchronous active-low reset
REQ_VALID  in  NREQ  per-requester request; held high until its REQ_DONE pulse
REQ_WRITE  in  NREQ  1 = write, 0 = read
REQ_ADDR  in  NREQ*ADDR_W  packed addresses, requester i at slice i
REQ_WDATA  in  NREQ*DATA_W  packed write data
REQ_WSTRB  in  NREQ*DATA_W/8  packed write strobes
REQ_DONE  out  NREQ  one-hot, 1-cycle completion pulse
REQ_RDATA  out  DATA_W  read data; valid while REQ_DONE is high for a read
REQ_RESP  out  2  BRESP/RRESP; valid while REQ_DONE is high
M_AXI_AWADDR  out  ADDR_W  write address
M_AXI_AWVALID  out  1
M_AXI_AWREADY  in  1
M_AXI_AWPROT  out  3  constant 3'b000
M_AXI_WDATA  out  DATA_W
M_AXI_WSTRB  out  DATA_W/8
M_AXI_WVALID  out  1
M_AXI_WREADY  in  1
M_AXI_BRESP  in  2
M_AXI_BVALID  in  1
M_AXI_BREADY  out  1
M_AXI_ARADDR  out  ADDR_W
M_AXI_ARVALID  out  1
M_AXI_ARREADY  in  1
M_AXI_ARPROT  out  3  constant 3'b000
M_AXI_RDATA  in  DATA_W
M_AXI_RRESP  in  2
M_AXI_RVALID  in  1
M_AXI_RREADY  out  1

Behaviour:
- Reset: all VALID/READY outputs 0, REQ_DONE 0, REQ_RDATA 0, REQ_RESP 0, addr/data/strobe outputs 0, state IDLE, round-robin pointer 0 (requester 0 highest priority).
- States: IDLE, WR (AW/W issue), WAIT_B, RD (AR issue), WAIT_R, DONE.
- IDLE: if any REQ_VALID is high, grant the first set bit searching upward from the pointer, with wrap. On that edge, register the grant index and latch its addr/wdata/wstrb into the M_AXI outputs.
  - Write: assert AWVALID and WVALID together, go to WR.
  - Read: assert ARVALID, go to RD.
  - Request-to-VALID latency: 1 cycle.
- WR: AWVALID drops on the cycle after the AWREADY handshake; WVALID drops on the cycle after the WREADY handshake. The two are independent, in either order or together. When both handshakes are complete, assert BREADY and go to WAIT_B.
- WAIT_B: on BVALID&&BREADY, capture BRESP, drop BREADY, go to DONE.
- RD: on ARVALID&&ARREADY, drop ARVALID, assert RREADY, go to WAIT_R.
- WAIT_R: on RVALID&&RREADY, capture RDATA/RRESP, drop RREADY, go to DONE.
- DONE: pulse REQ_DONE[grant] for exactly 1 cycle with REQ_RDATA/REQ_RESP valid. Set pointer = grant+1 (mod NREQ) and return to IDLE. A new grant is possible on the following IDLE cycle, giving at least 1 idle cycle between transactions.
- Latched request fields are frozen from grant to DONE. Requester changes during that window are ignored. Deasserting REQ_VALID mid-transaction does not abort it; REQ_DONE still pulses.
- AXI rules:
  - Once any VALID is asserted, it and its payload hold stable until handshake.
  - Only one transaction is outstanding.
  - Reads and writes are never overlapped.
- SLVERR/DECERR are passed through unmodified; no retry.
- Writes leave REQ_RDATA unchanged (holds the last read value).
- Asynchronous reset mid-transaction: all outputs go to their reset values immediately and the transaction is abandoned. The downstream slave is also reset by the same ARESETn.

Test Plan:
- Single write, req0, addr 0x4, data 0x12345678, strb 0xF, AWREADY/WREADY high -> AW/W valid 1 cycle after request; REQ_DONE[0] pulses once; REQ_RESP=00.
- Read back, req1, addr 0x4 -> ARADDR=0x4; REQ_DONE[1] pulses with REQ_RDATA=0x12345678, REQ_RESP=00.
- Both requesters held high continuously -> grants alternate 0,1,0,1 across 4 transactions; no requester is granted twice in a row.
- WREADY 3 cycles before AWREADY, then reverse order -> BREADY asserted only after both handshakes; WDATA/AWADDR stable while valid.
- Slave stalls ARREADY 5 cycles, then RVALID with RRESP=10 -> ARVALID held for 5 cycles; REQ_RESP=10 on DONE.
- ARESETn low during WAIT_B -> BREADY, REQ_DONE and all VALIDs go to 0 with no clock edge; after release, a fresh request from requester 0 completes normally.
